cop_vtx_tracer: RTL and testbench

Trace producer for the coprocessor formal/sim checkers. It observes the CPU↔COP instruction handshake, COP register file and COP memory port, and assembles one retirement record per instruction. It emits each record as a one-cycle `vtx_valid` pulse carrying encoding, rs1, result, GPR writeback, pre/post CPR state and up to 4 memory transactions. Purely observational: it drives nothing back into the core.

---
 rtl/cop_vtx_tracer.sv | 133 +++++++++++++
 tb/tb_cop_vtx_tracer.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cop_vtx_tracer.sv
// cop_vtx_tracer: watches the CPU/COP handshake, CPR file and COP memory port,
// and emits one retirement record per instruction as a single-cycle strobe.
module cop_vtx_tracer #(
    parameter int NSLOT = 4
) (
    input  logic                   g_clk,
    input  logic                   g_resetn,
    input  logic                   cpu_insn_req,
    input  logic                   cop_insn_ack,
    input  logic [31:0]            cpu_insn_enc,
    input  logic [31:0]            cpu_rs1,
    input  logic                   cop_insn_rsp,
    input  logic [2:0]             cop_insn_result,
    input  logic                   cop_wen,
    input  logic [4:0]             cop_waddr,
    input  logic [31:0]            cop_wdata,
    input  logic [511:0]           cprs_flat,
    input  logic                   cop_mem_cen,
    input  logic                   cop_mem_wen,
    input  logic [31:0]            cop_mem_addr,
    input  logic [31:0]            cop_mem_wdata,
    input  logic [3:0]             cop_mem_ben,
    input  logic                   cop_mem_stall,
    input  logic [31:0]            cop_mem_rdata,
    input  logic                   cop_mem_error,
    output logic                   vtx_reset,
    output logic                   vtx_valid,
    output logic [31:0]            vtx_instr_enc,
    output logic [31:0]            vtx_instr_rs1,
    output logic [2:0]             vtx_instr_result,
    output logic                   vtx_instr_wen,
    output logic [4:0]             vtx_instr_waddr,
    output logic [31:0]            vtx_instr_wdata,
    output logic [511:0]           vtx_cprs_pre,
    output logic [511:0]           vtx_cprs_post,
    output logic [NSLOT-1:0]       vtx_mem_cen,
    output logic [NSLOT-1:0]       vtx_mem_wen,
    output logic [NSLOT-1:0]       vtx_mem_error,
    output logic [32*NSLOT-1:0]    vtx_mem_addr,
    output logic [32*NSLOT-1:0]    vtx_mem_wdata,
    output logic [32*NSLOT-1:0]    vtx_mem_rdata,
    output logic [4*NSLOT-1:0]     vtx_mem_ben,
    output logic                   vtx_mem_overflow,
    output logic                   vtx_proto_err
);
    localparam int SW = $clog2(NSLOT);
    typedef enum logic [1:0] {IDLE, BUSY, POST, EMIT} state_t;
    state_t state, state_nxt;
    logic accept, take, retire, mreq, room, perr, pend;
    logic [SW-1:0] pend_slot;
    logic [SW:0] cnt;
    assign accept = cpu_insn_req && cop_insn_ack;
    assign take = accept && (state == IDLE || state == EMIT);
    assign retire = cop_insn_rsp && state == BUSY;
    assign mreq = cop_mem_cen && !cop_mem_stall && state == BUSY;
    assign room = cnt < (SW+1)'(NSLOT);
    assign perr = (accept && (state == BUSY || state == POST)) ||
                  (cop_insn_rsp && state != BUSY) ||
                  (cop_mem_cen && state == IDLE && !accept);
    assign vtx_valid = state == EMIT;
    always_comb begin
        state_nxt = take ? BUSY : retire ? POST : state == POST ? EMIT : state == EMIT ? IDLE : state;
    end
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) state <= IDLE;
        else state <= state_nxt;
    end
    // Slot counter advances at request acceptance; the response lands one cycle later in pend_slot.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            vtx_reset        <= 1'b1;
            vtx_instr_enc    <= '0;
            vtx_instr_rs1    <= '0;
            vtx_instr_result <= '0;
            vtx_instr_wen    <= 1'b0;
            vtx_instr_waddr  <= '0;
            vtx_instr_wdata  <= '0;
            vtx_cprs_pre     <= '0;
            vtx_cprs_post    <= '0;
            vtx_mem_cen      <= '0;
            vtx_mem_wen      <= '0;
            vtx_mem_error    <= '0;
            vtx_mem_addr     <= '0;
            vtx_mem_wdata    <= '0;
            vtx_mem_rdata    <= '0;
            vtx_mem_ben      <= '0;
            vtx_mem_overflow <= 1'b0;
            vtx_proto_err    <= 1'b0;
            cnt              <= '0;
            pend             <= 1'b0;
            pend_slot        <= '0;
        end else begin
            vtx_reset <= 1'b0;
            pend      <= mreq && room;
            if (perr) vtx_proto_err <= 1'b1;
            if (take) begin
                vtx_instr_enc    <= cpu_insn_enc;
                vtx_instr_rs1    <= cpu_rs1;
                vtx_cprs_pre     <= cprs_flat;
                vtx_mem_cen      <= '0;
                vtx_mem_wen      <= '0;
                vtx_mem_error    <= '0;
                vtx_mem_addr     <= '0;
                vtx_mem_wdata    <= '0;
                vtx_mem_rdata    <= '0;
                vtx_mem_ben      <= '0;
                vtx_mem_overflow <= 1'b0;
                cnt              <= '0;
            end
            if (mreq && room) begin
                vtx_mem_cen[cnt[SW-1:0]]             <= 1'b1;
                vtx_mem_wen[cnt[SW-1:0]]             <= cop_mem_wen;
                vtx_mem_addr[32*cnt[SW-1:0] +: 32]   <= cop_mem_addr;
                vtx_mem_wdata[32*cnt[SW-1:0] +: 32]  <= cop_mem_wdata;
                vtx_mem_ben[4*cnt[SW-1:0] +: 4]      <= cop_mem_ben;
                pend_slot                            <= cnt[SW-1:0];
                cnt                                  <= cnt + 1'b1;
            end
            if (mreq && !room) vtx_mem_overflow <= 1'b1;
            if (pend) begin
                vtx_mem_rdata[32*pend_slot +: 32] <= cop_mem_rdata;
                vtx_mem_error[pend_slot]          <= cop_mem_error;
            end
            if (retire) begin
                vtx_instr_result <= cop_insn_result;
                vtx_instr_wen    <= cop_wen;
                vtx_instr_waddr  <= cop_waddr;
                vtx_instr_wdata  <= cop_wdata;
            end
            if (state == POST) vtx_cprs_post <= cprs_flat;
        end
    end
endmodule

// File: tb/tb_cop_vtx_tracer.sv
// tb_cop_vtx_tracer: scripted and randomized instructions checked against
// records predicted from the transactions the bench itself issues.
module tb_cop_vtx_tracer;
    logic g_clk = 0, g_resetn = 0;
    logic cpu_insn_req = 0, cop_insn_ack = 0, cop_insn_rsp = 0, cop_wen = 0;
    logic [31:0] cpu_insn_enc = 0, cpu_rs1 = 0, cop_wdata = 0;
    logic [2:0] cop_insn_result = 0;
    logic [4:0] cop_waddr = 0;
    logic [511:0] cprs_flat = 0;
    logic cop_mem_cen = 0, cop_mem_wen = 0, cop_mem_stall = 0, cop_mem_error = 0;
    logic [31:0] cop_mem_addr = 0, cop_mem_wdata = 0, cop_mem_rdata = 0;
    logic [3:0] cop_mem_ben = 0;
    logic vtx_reset, vtx_valid, vtx_instr_wen, vtx_mem_overflow, vtx_proto_err;
    logic [31:0] vtx_instr_enc, vtx_instr_rs1, vtx_instr_wdata;
    logic [2:0] vtx_instr_result;
    logic [4:0] vtx_instr_waddr;
    logic [511:0] vtx_cprs_pre, vtx_cprs_post;
    logic [3:0] vtx_mem_cen, vtx_mem_wen, vtx_mem_error;
    logic [127:0] vtx_mem_addr, vtx_mem_wdata, vtx_mem_rdata;
    logic [15:0] vtx_mem_ben;

    cop_vtx_tracer #(.NSLOT(4)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .cpu_insn_req(cpu_insn_req), .cop_insn_ack(cop_insn_ack),
        .cpu_insn_enc(cpu_insn_enc), .cpu_rs1(cpu_rs1),
        .cop_insn_rsp(cop_insn_rsp), .cop_insn_result(cop_insn_result),
        .cop_wen(cop_wen), .cop_waddr(cop_waddr), .cop_wdata(cop_wdata),
        .cprs_flat(cprs_flat),
        .cop_mem_cen(cop_mem_cen), .cop_mem_wen(cop_mem_wen),
        .cop_mem_addr(cop_mem_addr), .cop_mem_wdata(cop_mem_wdata),
        .cop_mem_ben(cop_mem_ben), .cop_mem_stall(cop_mem_stall),
        .cop_mem_rdata(cop_mem_rdata), .cop_mem_error(cop_mem_error),
        .vtx_reset(vtx_reset), .vtx_valid(vtx_valid),
        .vtx_instr_enc(vtx_instr_enc), .vtx_instr_rs1(vtx_instr_rs1),
        .vtx_instr_result(vtx_instr_result), .vtx_instr_wen(vtx_instr_wen),
        .vtx_instr_waddr(vtx_instr_waddr), .vtx_instr_wdata(vtx_instr_wdata),
        .vtx_cprs_pre(vtx_cprs_pre), .vtx_cprs_post(vtx_cprs_post),
        .vtx_mem_cen(vtx_mem_cen), .vtx_mem_wen(vtx_mem_wen),
        .vtx_mem_error(vtx_mem_error), .vtx_mem_addr(vtx_mem_addr),
        .vtx_mem_wdata(vtx_mem_wdata), .vtx_mem_rdata(vtx_mem_rdata),
        .vtx_mem_ben(vtx_mem_ben), .vtx_mem_overflow(vtx_mem_overflow),
        .vtx_proto_err(vtx_proto_err)
    );

    always #5 g_clk = ~g_clk;

    int n_vec = 0, n_miss = 0, pulses = 0;
    always @(posedge g_clk) if (vtx_valid === 1'b1) pulses <= pulses + 1;

    // instruction description consumed by run_insn
    logic [31:0] i_enc, i_rs1, i_wdata, cpr_val;
    logic [2:0] i_res;
    logic i_wen, cpr_wr, with_last;
    logic [4:0] i_waddr;
    int i_gap, n_ops, cpr_idx;
    logic [31:0] o_addr[8], o_wdata[8], o_rdata[8];
    logic o_wen[8], o_err[8];
    logic [3:0] o_ben[8];
    int o_stall[8], o_idle[8];
    // observed and predicted record
    logic [517:0] obs_misc, exp_misc;
    logic [511:0] obs_pre, obs_post, exp_pre, exp_post;
    logic obs_v1, obs_v2, obs_ovf1;

    function automatic logic [517:0] dut_misc();
        return {vtx_instr_enc, vtx_instr_rs1, vtx_instr_result, vtx_instr_wen, vtx_instr_waddr,
                vtx_instr_wdata, vtx_mem_cen, vtx_mem_wen, vtx_mem_error, vtx_mem_addr,
                vtx_mem_wdata, vtx_mem_rdata, vtx_mem_ben, vtx_mem_overflow};
    endfunction

    task automatic cyc();
        @(negedge g_clk);
    endtask

    task automatic idle_mem();
        cop_mem_cen = 0;
        cop_mem_stall = 1'($urandom);
        cop_mem_wen = 1'($urandom);
        cop_mem_addr = $urandom;
        cop_mem_wdata = $urandom;
        cop_mem_ben = 4'($urandom);
    endtask

    task automatic respond(input int p);
        if (p >= 0) begin
            cop_mem_rdata = o_rdata[p];
            cop_mem_error = o_err[p];
        end else begin
            cop_mem_rdata = $urandom;
            cop_mem_error = 1'($urandom);
        end
    endtask

    task automatic set_insn(input logic [31:0] enc, rs1, input logic [2:0] res,
                            input logic wen, input logic [4:0] waddr, input logic [31:0] wdata);
        i_enc = enc; i_rs1 = rs1; i_res = res; i_wen = wen; i_waddr = waddr; i_wdata = wdata;
        n_ops = 0; i_gap = 0; with_last = 0; cpr_wr = 0; cpr_idx = 0; cpr_val = 0;
    endtask

    task automatic set_op(input int i, input logic [31:0] addr, input logic wen,
                          input logic [3:0] ben, input logic [31:0] rdata, input logic err);
        o_addr[i] = addr; o_wen[i] = wen; o_ben[i] = ben; o_rdata[i] = rdata; o_err[i] = err;
        o_wdata[i] = $urandom; o_stall[i] = 0; o_idle[i] = 0;
    endtask

    task automatic rand_insn();
        set_insn($urandom, $urandom, 3'($urandom), 1'($urandom), 5'($urandom), $urandom);
        n_ops = $urandom_range(0, 6);
        i_gap = $urandom_range(0, 2);
        with_last = 1'($urandom);
        cpr_wr = 1'($urandom);
        cpr_idx = $urandom_range(0, 15);
        cpr_val = $urandom;
        for (int i = 0; i < n_ops; i++) begin
            set_op(i, $urandom, 1'($urandom), 4'($urandom), $urandom, 1'($urandom));
            o_stall[i] = $urandom_range(0, 2);
            o_idle[i] = $urandom_range(0, 1);
        end
    endtask

    // Called at a negedge; drives the accept in this cycle and returns at the negedge of the EMIT cycle.
    task automatic run_insn();
        logic [3:0] e_cen, e_wen, e_err;
        logic [127:0] e_addr, e_wdata, e_rdata;
        logic [15:0] e_ben;
        int prev, j;
        bit wl;
        wl = with_last && n_ops > 0;
        cpu_insn_req = 1; cop_insn_ack = 1; cpu_insn_enc = i_enc; cpu_rs1 = i_rs1;
        exp_pre = cprs_flat;
        cyc();
        obs_ovf1 = vtx_mem_overflow;
        cpu_insn_req = 0; cop_insn_ack = 0; cpu_insn_enc = $urandom; cpu_rs1 = $urandom;
        j = $urandom_range(0, 15);
        cprs_flat[32*j +: 32] = $urandom;
        prev = -1;
        for (int i = 0; i < n_ops; i++) begin
            repeat (o_idle[i]) begin idle_mem(); respond(prev); prev = -1; cyc(); end
            repeat (o_stall[i]) begin
                idle_mem(); cop_mem_cen = 1; cop_mem_stall = 1; respond(prev); prev = -1; cyc();
            end
            cop_mem_cen = 1; cop_mem_stall = 0; cop_mem_wen = o_wen[i]; cop_mem_addr = o_addr[i];
            cop_mem_wdata = o_wdata[i]; cop_mem_ben = o_ben[i];
            respond(prev); prev = i;
            if (!(wl && i == n_ops - 1)) cyc();
        end
        if (!wl) begin
            repeat (i_gap) begin idle_mem(); respond(prev); prev = -1; cyc(); end
            idle_mem(); respond(prev); prev = -1;
        end
        cop_insn_rsp = 1; cop_insn_result = i_res; cop_wen = i_wen; cop_waddr = i_waddr; cop_wdata = i_wdata;
        cyc();
        obs_v1 = vtx_valid;
        cop_insn_rsp = 0; cop_insn_result = 3'($urandom); cop_wen = 1'($urandom);
        cop_waddr = 5'($urandom); cop_wdata = $urandom;
        idle_mem(); respond(prev);
        if (cpr_wr) cprs_flat[32*cpr_idx +: 32] = cpr_val;
        exp_post = cprs_flat;
        cyc();
        obs_v2 = vtx_valid;
        obs_misc = dut_misc();
        obs_pre = vtx_cprs_pre;
        obs_post = vtx_cprs_post;
        e_cen = 0; e_wen = 0; e_err = 0; e_addr = 0; e_wdata = 0; e_rdata = 0; e_ben = 0;
        for (int k = 0; k < 4 && k < n_ops; k++) begin
            e_cen[k] = 1; e_wen[k] = o_wen[k]; e_err[k] = o_err[k];
            e_addr[32*k +: 32] = o_addr[k]; e_wdata[32*k +: 32] = o_wdata[k];
            e_rdata[32*k +: 32] = o_rdata[k]; e_ben[4*k +: 4] = o_ben[k];
        end
        exp_misc = {i_enc, i_rs1, i_res, i_wen, i_waddr, i_wdata, e_cen, e_wen, e_err,
                    e_addr, e_wdata, e_rdata, e_ben, 1'(n_ops > 4)};
    endtask

    task automatic test_reset();
        cprs_flat = {16{$urandom}};
        repeat (3) cyc();
        n_vec++; if (vtx_reset !== 1'b1) begin n_miss++; $display("FAIL reset_flag got=%b exp=1", vtx_reset); end
        n_vec++; if (vtx_valid !== 1'b0 || vtx_proto_err !== 1'b0) begin
            n_miss++; $display("FAIL reset_strobes got valid=%b err=%b exp=0", vtx_valid, vtx_proto_err); end
        n_vec++; if (dut_misc() !== '0) begin n_miss++; $display("FAIL reset_record got=%h exp=0", dut_misc()); end
        n_vec++; if (vtx_cprs_pre !== '0 || vtx_cprs_post !== '0) begin
            n_miss++; $display("FAIL reset_cprs got pre=%h post=%h exp=0", vtx_cprs_pre, vtx_cprs_post); end
        #2 g_resetn = 1;
        #1;
        n_vec++; if (vtx_reset !== 1'b1) begin n_miss++; $display("FAIL reset_hold got=%b exp=1", vtx_reset); end
        @(posedge g_clk); #1;
        n_vec++; if (vtx_reset !== 1'b0) begin n_miss++; $display("FAIL reset_drop got=%b exp=0", vtx_reset); end
        cyc();
    endtask

    task automatic test_alu();
        logic [31:0] old3;
        old3 = cprs_flat[3*32 +: 32];
        set_insn(32'h0000_202B, 32'd5, 3'd0, 1'b1, 5'd7, 32'hDEAD_BEEF);
        i_gap = 2; cpr_wr = 1; cpr_idx = 3; cpr_val = 32'h1234;
        run_insn();
        n_vec++; if (obs_v1 !== 1'b0 || obs_v2 !== 1'b1) begin
            n_miss++; $display("FAIL alu_latency got r+1=%b r+2=%b exp 0,1", obs_v1, obs_v2); end
        n_vec++; if (obs_pre[3*32 +: 32] !== old3) begin
            n_miss++; $display("FAIL alu_pre_cpr3 got=%h exp=%h", obs_pre[3*32 +: 32], old3); end
        n_vec++; if (obs_post[3*32 +: 32] !== 32'h1234) begin
            n_miss++; $display("FAIL alu_post_cpr3 got=%h exp=00001234", obs_post[3*32 +: 32]); end
        n_vec++; if (vtx_mem_cen !== 4'b0000) begin n_miss++; $display("FAIL alu_mem_cen got=%b exp=0000", vtx_mem_cen); end
        n_vec++; if (obs_misc !== exp_misc) begin n_miss++; $display("FAIL alu_record got=%h exp=%h", obs_misc, exp_misc); end
        n_vec++; if (obs_pre !== exp_pre || obs_post !== exp_post) begin
            n_miss++; $display("FAIL alu_cprs got pre=%h exp=%h", obs_pre, exp_pre); end
        cyc();
        n_vec++; if (vtx_valid !== 1'b0) begin n_miss++; $display("FAIL alu_one_cycle got=%b exp=0", vtx_valid); end
        n_vec++; if (vtx_instr_enc !== 32'h0000_202B || vtx_instr_wdata !== 32'hDEAD_BEEF) begin
            n_miss++; $display("FAIL alu_hold got enc=%h wdata=%h exp 0000202b deadbeef", vtx_instr_enc, vtx_instr_wdata); end
    endtask

    task automatic test_loads_store();
        set_insn($urandom, $urandom, 3'd1, 1'b0, 5'd0, $urandom);
        n_ops = 3; with_last = 1;
        set_op(0, 32'h100, 1'b0, 4'hF, 32'hA5A5_A5A5, 1'b0);
        set_op(1, 32'h104, 1'b0, 4'hF, $urandom, 1'b1);
        set_op(2, 32'h108, 1'b1, 4'h3, $urandom, 1'b0);
        run_insn();
        n_vec++; if (vtx_mem_cen !== 4'b0111) begin n_miss++; $display("FAIL ls_cen got=%b exp=0111", vtx_mem_cen); end
        n_vec++; if (vtx_mem_rdata[31:0] !== 32'hA5A5_A5A5) begin
            n_miss++; $display("FAIL ls_slot0_rdata got=%h exp=a5a5a5a5", vtx_mem_rdata[31:0]); end
        n_vec++; if (vtx_mem_error !== 4'b0010) begin n_miss++; $display("FAIL ls_error got=%b exp=0010", vtx_mem_error); end
        n_vec++; if (vtx_mem_wen[2] !== 1'b1 || vtx_mem_ben[11:8] !== 4'h3) begin
            n_miss++; $display("FAIL ls_store got wen=%b ben=%h exp 1 3", vtx_mem_wen[2], vtx_mem_ben[11:8]); end
        n_vec++; if (vtx_mem_overflow !== 1'b0) begin n_miss++; $display("FAIL ls_overflow got=%b exp=0", vtx_mem_overflow); end
        n_vec++; if (obs_misc !== exp_misc) begin n_miss++; $display("FAIL ls_record got=%h exp=%h", obs_misc, exp_misc); end
        cyc();
    endtask

    task automatic test_overflow();
        set_insn($urandom, $urandom, 3'd2, 1'b1, 5'd9, $urandom);
        n_ops = 5;
        for (int i = 0; i < 5; i++) set_op(i, 32'h10 * i, 1'($urandom), 4'($urandom), $urandom, 1'($urandom));
        run_insn();
        n_vec++; if (vtx_mem_overflow !== 1'b1 || vtx_mem_cen !== 4'hF) begin
            n_miss++; $display("FAIL ovf_flag got ovf=%b cen=%b exp 1 1111", vtx_mem_overflow, vtx_mem_cen); end
        n_vec++; if (vtx_mem_addr[127:96] !== 32'h30) begin
            n_miss++; $display("FAIL ovf_slot3_addr got=%h exp=00000030", vtx_mem_addr[127:96]); end
        n_vec++; if (obs_misc !== exp_misc) begin n_miss++; $display("FAIL ovf_record got=%h exp=%h", obs_misc, exp_misc); end
        cyc();
        set_insn($urandom, $urandom, 3'd0, 1'b0, 5'd0, $urandom);
        run_insn();
        n_vec++; if (obs_ovf1 !== 1'b0) begin n_miss++; $display("FAIL ovf_clear_on_accept got=%b exp=0", obs_ovf1); end
        n_vec++; if (obs_misc !== exp_misc) begin n_miss++; $display("FAIL ovf_next_record got=%h exp=%h", obs_misc, exp_misc); end
        cyc();
    endtask

    task automatic test_stall();
        set_insn($urandom, $urandom, 3'd3, 1'b0, 5'd1, $urandom);
        n_ops = 1;
        set_op(0, 32'h200, 1'b1, 4'hC, $urandom, 1'b0);
        o_stall[0] = 2;
        run_insn();
        n_vec++; if (vtx_mem_cen !== 4'b0001 || vtx_mem_addr[31:0] !== 32'h200) begin
            n_miss++; $display("FAIL stall_slot got cen=%b addr=%h exp 0001 00000200", vtx_mem_cen, vtx_mem_addr[31:0]); end
        n_vec++; if (obs_misc !== exp_misc) begin n_miss++; $display("FAIL stall_record got=%h exp=%h", obs_misc, exp_misc); end
        cyc();
    endtask

    task automatic test_back_to_back();
        logic [511:0] post1;
        int p0;
        p0 = pulses;
        rand_insn();
        run_insn();
        post1 = exp_post;
        n_vec++; if (obs_misc !== exp_misc || obs_v2 !== 1'b1) begin
            n_miss++; $display("FAIL b2b_first got=%h exp=%h", obs_misc, exp_misc); end
        rand_insn();
        run_insn();
        n_vec++; if (obs_pre !== post1) begin n_miss++; $display("FAIL b2b_pre_eq_post got=%h exp=%h", obs_pre, post1); end
        n_vec++; if (obs_misc !== exp_misc || obs_v2 !== 1'b1) begin
            n_miss++; $display("FAIL b2b_second got=%h exp=%h", obs_misc, exp_misc); end
        cyc();
        n_vec++; if (pulses - p0 !== 2) begin n_miss++; $display("FAIL b2b_pulses got=%0d exp=2", pulses - p0); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            rand_insn();
            run_insn();
            n_vec++; if (obs_v1 !== 1'b0 || obs_v2 !== 1'b1) begin
                n_miss++; $display("FAIL rnd%0d_latency got %b%b exp 01", n, obs_v1, obs_v2); end
            n_vec++; if (obs_misc !== exp_misc) begin
                n_miss++; $display("FAIL rnd%0d_record got=%h exp=%h", n, obs_misc, exp_misc); end
            n_vec++; if (obs_pre !== exp_pre || obs_post !== exp_post) begin
                n_miss++; $display("FAIL rnd%0d_cprs got post=%h exp=%h", n, obs_post, exp_post); end
            if (n == 29 || $urandom_range(0, 2) != 0) repeat ($urandom_range(1, 3)) cyc();
        end
        n_vec++; if (vtx_proto_err !== 1'b0) begin n_miss++; $display("FAIL rnd_no_proto_err got=%b exp=0", vtx_proto_err); end
    endtask

    task automatic test_proto_err();
        int p0;
        p0 = pulses;
        cop_insn_rsp = 1; cop_insn_result = ~i_res; cop_wdata = ~i_wdata;
        cyc();
        cop_insn_rsp = 0;
        n_vec++; if (vtx_proto_err !== 1'b1) begin n_miss++; $display("FAIL perr_rsp_idle got=%b exp=1", vtx_proto_err); end
        repeat (4) cyc();
        n_vec++; if (vtx_proto_err !== 1'b1) begin n_miss++; $display("FAIL perr_sticky got=%b exp=1", vtx_proto_err); end
        n_vec++; if (pulses !== p0 || vtx_instr_wdata !== i_wdata) begin
            n_miss++; $display("FAIL perr_ignored got pulses=%0d wdata=%h exp %0d %h", pulses, vtx_instr_wdata, p0, i_wdata); end
    endtask

    task automatic test_reset_mid();
        int p0;
        rand_insn();
        cpu_insn_req = 1; cop_insn_ack = 1; cpu_insn_enc = i_enc; cpu_rs1 = i_rs1;
        cyc();
        cpu_insn_req = 0; cop_insn_ack = 0;
        cop_mem_cen = 1; cop_mem_stall = 0; cop_mem_addr = $urandom;
        cyc();
        idle_mem();
        #2 g_resetn = 0;
        #1;
        p0 = pulses;
        n_vec++; if (vtx_reset !== 1'b1 || vtx_valid !== 1'b0 || vtx_proto_err !== 1'b0) begin
            n_miss++; $display("FAIL rstmid_flags got reset=%b valid=%b err=%b exp 1 0 0", vtx_reset, vtx_valid, vtx_proto_err); end
        n_vec++; if (dut_misc() !== '0 || vtx_cprs_pre !== '0 || vtx_cprs_post !== '0) begin
            n_miss++; $display("FAIL rstmid_record got=%h exp=0", dut_misc()); end
        repeat (2) cyc();
        g_resetn = 1;
        #1;
        n_vec++; if (vtx_reset !== 1'b1) begin n_miss++; $display("FAIL rstmid_hold got=%b exp=1", vtx_reset); end
        @(posedge g_clk); #1;
        n_vec++; if (vtx_reset !== 1'b0) begin n_miss++; $display("FAIL rstmid_drop got=%b exp=0", vtx_reset); end
        repeat (4) cyc();
        n_vec++; if (pulses !== p0) begin n_miss++; $display("FAIL rstmid_no_valid got=%0d exp=%0d", pulses, p0); end
        n_vec++; if (vtx_proto_err !== 1'b0) begin n_miss++; $display("FAIL rstmid_err_clear got=%b exp=0", vtx_proto_err); end
        cop_mem_cen = 1; cop_mem_stall = 0;
        cyc();
        cop_mem_cen = 0;
        n_vec++; if (vtx_proto_err !== 1'b1) begin n_miss++; $display("FAIL perr_cen_idle got=%b exp=1", vtx_proto_err); end
        rand_insn();
        run_insn();
        n_vec++; if (obs_misc !== exp_misc || obs_v2 !== 1'b1) begin
            n_miss++; $display("FAIL rstmid_recover got=%h exp=%h", obs_misc, exp_misc); end
        cyc();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_alu();
        test_loads_store();
        test_overflow();
        test_stall();
        test_back_to_back();
        test_random();
        test_proto_err();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
